// File: rtl/rf_multiport_pkg.sv
// Shared defaults and bus typedefs for the multiport register file slice.
// The optional same-cycle write bypass is selected with the RF_BYPASS_EN macro.
package rf_multiport_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);
  localparam int RF_NRD  = 2;
  localparam int RF_NWR  = 2;

  typedef logic [RF_XLEN-1:0] data_bus_t;
  typedef logic [RF_AW-1:0]   reg_addr_bus_t;

endpackage

// File: rtl/rf_multiport_if.sv
// Decode/writeback side bus of the register file: read ports, write ports, issue and flush.
interface rf_multiport_if
  import rf_multiport_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW,
  parameter int NRD  = RF_NRD,
  parameter int NWR  = RF_NWR
);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                flush;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_addr, flush,
    output rdata, rbusy
  );

endinterface

// File: rtl/rf_multiport_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears everything.
module rf_scoreboard
  import rf_multiport_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int NRD  = RF_NRD,
  parameter int NWR  = RF_NWR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int a = 1; a < NREG; a++) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == AW'(a)))
          busy_nxt[a] = 1'b0;
      end
      if (iss_valid && (iss_addr == AW'(a)))
        busy_nxt[a] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush)
      busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++)
      rbusy[i] = busy[raddr[i*AW +: AW]];
  end

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file with x0 hardwired to zero and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module rf_multiport
  import rf_multiport_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int NRD  = RF_NRD,
  parameter int NWR  = RF_NWR
) (
  input  logic         clk,
  input  logic         rst,
  rf_multiport_if.slave bus
);

  logic [XLEN-1:0] mem    [NREG];
  logic [XLEN-1:0] wr_val [NREG];
  logic [NREG-1:0] wr_hit;
  logic [NRD-1:0]  sb_rbusy;
  logic [AW-1:0]   ra;

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_comb begin
    wr_hit = '0;
    for (int a = 0; a < NREG; a++)
      wr_val[a] = mem[a];
    for (int a = 1; a < NREG; a++) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && (bus.waddr[j*AW +: AW] == AW'(a))) begin
          wr_hit[a] = 1'b1;
          wr_val[a] = bus.wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NREG; a++)
        mem[a] <= '0;
    end else begin
      for (int a = 1; a < NREG; a++) begin
        if (wr_hit[a])
          mem[a] <= wr_val[a];
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .flush     (bus.flush),
    .we        (bus.we),
    .waddr     (bus.waddr),
    .raddr     (bus.raddr),
    .rbusy     (sb_rbusy)
  );

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    ra        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.raddr[i*AW +: AW];
`ifdef RF_BYPASS_EN
      if (ra != '0)
        bus.rdata[i*XLEN +: XLEN] = wr_val[ra];
      // wr_hit[0] is never set, so x0 keeps rbusy low here.
      if (wr_hit[ra])
        bus.rbusy[i] = bus.iss_valid && (bus.iss_addr == ra) && !bus.flush;
      else
        bus.rbusy[i] = sb_rbusy[i];
`else
      if (ra != '0)
        bus.rdata[i*XLEN +: XLEN] = mem[ra];
      bus.rbusy[i] = sb_rbusy[i];
`endif
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed scoreboard bench for rf_multiport: expectations queued at drive time, compared after settle.
module tb_rf_multiport;
  import rf_multiport_pkg::*;

  localparam int XLEN = RF_XLEN;
  localparam int AW   = RF_AW;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          port;
    bit          is_busy;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sbq[$];

  rf_multiport_if bus ();

  rf_multiport dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we        = '0;
    bus.iss_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    bus.we[port]                  = 1'b1;
    bus.waddr[port*AW +: AW]      = AW'(a);
    bus.wdata[port*XLEN +: XLEN]  = d;
  endtask

  task automatic iss(input int a);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(a);
  endtask

  task automatic rd(input int port, input int a, input logic [31:0] ed, input bit eb, input string tag);
    exp_t e;
    bus.raddr[port*AW +: AW] = AW'(a);
    e.tag = {tag, "_data"}; e.port = port; e.is_busy = 1'b0; e.exp = ed;
    sbq.push_back(e);
    e.tag = {tag, "_busy"}; e.is_busy = 1'b1; e.exp = {31'b0, eb};
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.is_busy)
        obs = {31'b0, bus.rbusy[e.port]};
      else
        obs = bus.rdata[e.port*XLEN +: XLEN];
      check_val(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.raddr    = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.iss_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state across all addresses on both ports
    for (int a = 0; a < 32; a++) begin
      rd(0, a, 32'h0, 1'b0, "rst_p0");
      rd(1, 31 - a, 32'h0, 1'b0, "rst_p1");
      drain();
    end

    // x0 ignores writes and issue
    wr(0, 0, 32'hDEADBEEF);
    iss(0);
    rd(0, 0, 32'h0, 1'b0, "x0_same");
    drain();
    tick();
    rd(0, 0, 32'h0, 1'b0, "x0_next");
    drain();

    // Write-port conflicts and dual distinct writes
    wr(0, 5, 32'h1111);
    wr(1, 5, 32'h2222);
    tick();
    rd(0, 5, 32'h2222, 1'b0, "conf_p0");
    rd(1, 5, 32'h2222, 1'b0, "conf_p1");
    drain();
    wr(0, 6, 32'hAAAA);
    wr(1, 7, 32'hBBBB);
    tick();
    rd(0, 6, 32'hAAAA, 1'b0, "dual_x6");
    rd(1, 7, 32'hBBBB, 1'b0, "dual_x7");
    drain();
    wr(0, 5, 32'h3333);
    tick();
    rd(0, 5, 32'h3333, 1'b0, "p0_only");
    drain();

    // Scoreboard set/clear
    iss(7);
    tick();
    rd(0, 7, 32'hBBBB, 1'b1, "iss7");
    drain();
    iss(7);
    tick();
    rd(0, 7, 32'hBBBB, 1'b1, "iss7_again");
    drain();
    wr(0, 8, 32'h88);
    tick();
    rd(0, 7, 32'hBBBB, 1'b1, "x8_no_clr");
    rd(1, 8, 32'h88, 1'b0, "x8_wr");
    drain();
    wr(0, 7, 32'h55);
    tick();
    rd(0, 7, 32'h55, 1'b0, "wb7");
    drain();
    iss(7);
    wr(1, 7, 32'h66);
    tick();
    rd(0, 7, 32'h66, 1'b1, "iss_wb7");
    drain();
    wr(1, 7, 32'h77);
    tick();
    rd(0, 7, 32'h77, 1'b0, "wb7_p1");
    drain();

    // Flush beats a same-cycle issue
    iss(3);
    tick();
    iss(4);
    tick();
    rd(0, 3, 32'h0, 1'b1, "pre_fl_x3");
    rd(1, 4, 32'h0, 1'b1, "pre_fl_x4");
    drain();
    bus.flush = 1'b1;
    iss(9);
    tick();
    rd(0, 3, 32'h0, 1'b0, "fl_x3");
    rd(1, 4, 32'h0, 1'b0, "fl_x4");
    drain();
    rd(0, 9, 32'h0, 1'b0, "fl_x9");
    drain();

    // Same-cycle write/read visibility
    iss(10);
    tick();
    wr(0, 10, 32'hABCD);
    rd(0, 10, BYP ? 32'hABCD : 32'h0, BYP ? 1'b0 : 1'b1, "byp");
    drain();
    iss(10);
    rd(0, 10, BYP ? 32'hABCD : 32'h0, 1'b1, "byp_iss");
    drain();
    tick();
    rd(0, 10, 32'hABCD, 1'b1, "byp_after");
    drain();

    // Asynchronous reset in mid-cycle
    wr(0, 12, 32'h12);
    tick();
    rd(0, 12, 32'h12, 1'b0, "pre_rst_x12");
    rd(1, 10, 32'hABCD, 1'b1, "pre_rst_x10");
    drain();
    #2;
    rst = 1'b0;
    rd(0, 12, 32'h0, 1'b0, "arst_x12");
    rd(1, 10, 32'h0, 1'b0, "arst_x10");
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd(0, 5, 32'h0, 1'b0, "post_rst_x5");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
